// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add computed one nibble per cycle through a single 4-bit adder
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [4:0]       nib;
  logic             last;

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign sum       = sum_q;
  assign carryout  = cout_q;
  assign overflow  = ovf_q;

  // next-state: operand capture, one nibble pass per ADD cycle, handshake out of DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    nib     = {1'b0, a_q[4*idx_q +: 4]} + {1'b0, b_q[4*idx_q +: 4]} + {4'b0, carry_q};
    last    = idx_q == IW'(NIB - 1);
    if (state_q == IDLE && in_valid) begin
      a_d     = a;
      b_d     = b;
      carry_d = 1'b0;
      idx_d   = '0;
      state_d = ADD;
    end
    if (state_q == ADD) begin
      sum_d[4*idx_q +: 4] = nib[3:0];
      carry_d = nib[4];
      idx_d   = last ? idx_q : idx_q + IW'(1);
      state_d = last ? DONE : ADD;
      cout_d  = last ? nib[4] : cout_q;
      ovf_d   = last ? (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib[3] != a_q[WIDTH-1]) : ovf_q;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end

  // state registers with synchronous active-low reset that aborts any operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: scoreboard bench for nibble_serial_adder at WIDTH=16
module tb_nibble_serial_adder;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic        in_ready, out_valid, carryout, overflow, busy;
  int          n_tests = 0, n_fail = 0, cyc = 0;

  typedef struct packed {logic [15:0] s; logic c; logic o;} res_t;
  res_t sb[$];

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carryout(carryout), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] f;
    res_t r;
    f   = {1'b0, x} + {1'b0, y};
    r.s = f[15:0];
    r.c = f[16];
    r.o = (x[15] == y[15]) && (f[15] != x[15]);
    return r;
  endfunction

  // scoreboard: compare each result as its handshake completes
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        res_t e;
        e = sb.pop_front();
        chk("sum", sum, e.s);
        chk("carryout", carryout, e.c);
        chk("overflow", overflow, e.o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("in_ready_timeout", in_ready, 1);
  endtask

  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input int bp);
    int   n = 0;
    res_t e;
    wait_ready();
    e        = model(x, y);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", n, 4);
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      a        = 16'h1111;
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", sum, e.s);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int last_acc, n;
    res_t e;
    logic [15:0] x, y;
    step();
    step();
    chk("rst_sum", sum, 0);
    chk("rst_carryout", carryout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);

    do_op(16'h0005, 16'h0009, 0);
    do_op(16'h0FFF, 16'h0001, 0);
    do_op(16'hFFFF, 16'h0001, 0);
    do_op(16'h7FFF, 16'h0001, 0);
    do_op(16'h8000, 16'h8000, 0);
    do_op(16'h4321, 16'hC0DE, 10);
    chk("post_retain_sum", sum, 16'h03FF);
    chk("post_idle_busy", busy, 0);

    // abort an operation with reset on its second ADD cycle
    a        = 16'h1234;
    b        = 16'h1111;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("abort_sum", sum, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_carryout", carryout, 0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      n += out_valid;
    end
    chk("abort_no_result", n, 0);
    do_op(16'h0002, 16'h0003, 0);

    // back-to-back with both handshakes held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    last_acc  = -1;
    for (int k = 0; k < 8; k++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      a = x;
      b = y;
      wait_ready();
      e = model(x, y);
      sb.push_back(e);
      if (last_acc >= 0) chk("b2b_interval", cyc - last_acc, 6);
      last_acc = cyc;
      step();
      a = 16'hDEAD;
      b = 16'hBEEF;
    end
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
